// File: rtl/reg_dump_uart_tx.sv
// Register-dump UART 8N1 transmitter: one accepted request snapshots R0..R3
// and sends a frame of SYNC_BYTE, r0, r1, r2, r3, checksum with no inter-byte gap.
module reg_dump_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dump_req,
  input  logic [7:0] r0view,
  input  logic [7:0] r1view,
  input  logic [7:0] r2view,
  input  logic [7:0] r3view,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int unsigned CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned SHADOW_N  = 5;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(SHADOW_N);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(BYTE_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e                            state_q,    state_d;
  logic [CNT_W-1:0]                  clk_cnt_q,  clk_cnt_d;
  logic [IDX_W-1:0]                  bit_cnt_q,  bit_cnt_d;
  logic [IDX_W-1:0]                  byte_idx_q, byte_idx_d;
  logic [SHADOW_N-1:0][BYTE_W-1:0]   shadow_q,   shadow_d;
  logic                              tx_q,       tx_d;
  logic                              busy_q,     busy_d;
  logic                              done_q,     done_d;
  logic                              overrun_q,  overrun_d;

  logic [BYTE_W-1:0] csum_c;
  logic [BYTE_W-1:0] cur_byte_c;
  logic [IDX_W-1:0]  nxt_bit_c;
  logic              bit_end_c;

  assign csum_c    = r0view + r1view + r2view + r3view;
  assign bit_end_c = (clk_cnt_q == CNT_LAST);
  assign nxt_bit_c = bit_cnt_q + IDX_W'(1);

  // Byte currently on the wire: index 0 is the sync byte, 1..5 come from the shadow.
  always_comb begin
    cur_byte_c = SYNC_BYTE;
    case (byte_idx_q)
      3'd1:    cur_byte_c = shadow_q[0];
      3'd2:    cur_byte_c = shadow_q[1];
      3'd3:    cur_byte_c = shadow_q[2];
      3'd4:    cur_byte_c = shadow_q[3];
      3'd5:    cur_byte_c = shadow_q[4];
      default: cur_byte_c = SYNC_BYTE;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    shadow_d   = shadow_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overrun_d  = dump_req & busy_q;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (dump_req) begin
          shadow_d   = {csum_c, r3view, r2view, r1view, r0view};
          state_d    = S_START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          clk_cnt_d  = '0;
          bit_cnt_d  = '0;
          byte_idx_d = '0;
        end
      end

      S_START: begin
        if (bit_end_c) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = S_DATA;
          tx_d      = cur_byte_c[0];
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (bit_end_c) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = nxt_bit_c;
            tx_d      = cur_byte_c[nxt_bit_c];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (bit_end_c) begin
          clk_cnt_d = '0;
          // Next start bit follows the stop bit directly.
          if (byte_idx_q < LAST_BYTE) begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
            state_d    = S_START;
            tx_d       = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      shadow_q   <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      shadow_q   <= shadow_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: doc/reg_dump_uart_tx.md
Name: reg_dump_uart_tx

Overview:
- Reads the CPU's four 8-bit register views and sends them out as one serial frame over a UART 8N1 transmitter. The transmitter feeds the Mojo's serial link.
- This is the readback path that complements the DIP-switch and button instruction-entry path. A host sees register state after each executed instruction without using the LEDs.
- It sits beside the CPU core in the top level. The core's execute strobe (or a debounced button) drives `dump_req`. `tx` goes to the serial pin.

Parameters:
- CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200 baud). Legal range is 2 or more.
- SYNC_BYTE, default 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- dump_req  input  1  request one register dump. Level is sampled every cycle.
- r0view  input  8  register R0 contents.
- r1view  input  8  register R1 contents.
- r2view  input  8  register R2 contents.
- r3view  input  8  register R3 contents.
- tx  output  1  UART serial out. Idle level is high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse when a frame completes.
- overrun  output  1  one-cycle pulse when a request is dropped.

Behaviour:
- Reset (rst=1 at a clock edge):
  - tx=1, busy=0, done=0, overrun=0.
  - FSM goes to IDLE; bit counter, cycle counter and byte index are cleared.
  - Reset mid-frame abandons the frame. tx=1 in the cycle after reset and no done pulse is produced.
- Accept:
  - A cycle with dump_req=1, busy=0 and rst=0 is the accept cycle.
  - At that edge, r0view..r3view are snapshotted into a 5-byte shadow.
  - The checksum byte is (r0+r1+r2+r3) mod 256, computed with 8-bit wrap.
  - Register changes after the accept edge do not affect the frame.
- Frame format: 6 bytes in this order: SYNC_BYTE, r0, r1, r2, r3, checksum.
- Byte format:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - There is no inter-byte gap: each stop bit is followed directly by the next start bit.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on accept.
  - START→DATA after CLKS_PER_BIT cycles.
  - DATA→STOP after 8 bits.
  - STOP→START (next byte) if byte index is below 5, else STOP→IDLE.
- Latency:
  - In the cycle after accept: busy=1 and tx=0 (start bit of SYNC_BYTE).
  - The frame occupies exactly 60*CLKS_PER_BIT cycles with busy=1.
  - In the following cycle: busy=0, done=1, tx=1.
- tx is driven from a register: no combinational path from inputs to tx.
- done lasts exactly one cycle.
- A dump_req in the done cycle is accepted, since busy=0. The next start bit begins the cycle after, giving back-to-back frames with one idle-high cycle between them.
- Overrun: dump_req=1 while busy=1 is dropped and overrun pulses for one cycle in the next cycle. There is no queueing.
  - A request held high across a whole frame pulses overrun each cycle it is held. It is also accepted in the done cycle.
- Level semantics: dump_req held continuously high produces continuous back-to-back frames.
- A request coincident with rst=1 is ignored.

Test Plan:
1. CLKS_PER_BIT=4; r0..r3=01,02,03,1E; pulse dump_req one cycle → tx bytes A5,01,02,03,1E,24 LSB-first. busy high for 240 cycles, then done for 1 cycle with tx=1.
2. r0..r3=FF,FF,FF,FF → checksum byte FC (wrap of 0x3FC). Frame bytes A5,FF,FF,FF,FF,FC.
3. Snapshot: start a frame with r3=1E, then change r3 to 55 ten cycles after accept → transmitted r3 byte is still 1E.
4. Overrun: while busy, pulse dump_req once at cycle 50 → overrun=1 exactly one cycle later. The current frame is unchanged and no second frame follows.
5. Reset mid-frame: assert rst during byte 2, DATA state → next cycle tx=1, busy=0, no done pulse. A new dump_req then produces a complete, correct frame.
6. Back-to-back: assert dump_req exactly in the done cycle → the next cycle has tx=0 and busy=1. The second frame is bit-exact against the new register snapshot.
